// File: rtl/aes_word_loader_if.sv
// Word-loader bus: word input side, assembled key/IV/ciphertext outputs and the AES consume handshake.
// slave is the loader's view; master is the producer/consumer environment's view.
interface aes_word_loader_if #(
  parameter int unsigned WORD_W = 32
);
  logic [WORD_W-1:0]   data_i;
  logic [1:0]          dsel_i;
  logic                dvalid_i;
  logic                dready_o;
  logic [8*WORD_W-1:0] k_o;
  logic                kvalid_o;
  logic [4*WORD_W-1:0] iv_o;
  logic                ivalid_o;
  logic [4*WORD_W-1:0] c_o;
  logic                cvalid_o;
  logic                aes_ready_i;
  logic                err_o;

  modport slave (
    input  data_i, dsel_i, dvalid_i, aes_ready_i,
    output dready_o, k_o, kvalid_o, iv_o, ivalid_o, c_o, cvalid_o, err_o
  );

  modport master (
    output data_i, dsel_i, dvalid_i, aes_ready_i,
    input  dready_o, k_o, kvalid_o, iv_o, ivalid_o, c_o, cvalid_o, err_o
  );
endinterface

// File: rtl/aes_word_loader.sv
// Assembles 32-bit words into a 256-bit key, 128-bit IV or 128-bit ciphertext block, big-endian,
// through one shared assembly register; ciphertext is handed to the AES core with valid/ready.
module aes_word_loader #(
  parameter int unsigned WORD_W = 32
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           enable_i,
  aes_word_loader_if.slave bus
);
  localparam int unsigned KeyW = 8 * WORD_W;
  localparam int unsigned BlkW = 4 * WORD_W;
  localparam int unsigned LsbW = $clog2(KeyW);

  localparam logic [1:0] SelCt   = 2'b00;
  localparam logic [1:0] SelIv   = 2'b01;
  localparam logic [1:0] SelKey  = 2'b10;
  localparam logic [1:0] SelRsvd = 2'b11;

  typedef enum logic [1:0] {StIdle, StFill, StHold} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [1:0]        tgt_q, tgt_d;
  logic [KeyW-1:0]   asm_q, asm_d;
  logic [KeyW-1:0]   k_q, k_d;
  logic [BlkW-1:0]   iv_q, iv_d;
  logic [BlkW-1:0]   c_q, c_d;
  logic              cvalid_q, cvalid_d;
  logic              kvalid_q, kvalid_d;
  logic              ivalid_q, ivalid_d;
  logic              err_q, err_d;

  logic              dready;
  logic              accept;
  logic              consume;
  logic [2:0]        idx;
  logic              last;
  logic [LsbW-1:0]   word_lsb;
  logic [BlkW-1:0]   blk;

  assign dready  = resetn & enable_i & (state_q != StHold);
  assign accept  = bus.dvalid_i & dready;
  assign consume = enable_i & cvalid_q & bus.aes_ready_i;

  // A word for a different target than the partial unit restarts at word 0.
  assign idx      = (state_q == StFill && bus.dsel_i == tgt_q) ? cnt_q : 3'd0;
  assign last     = (bus.dsel_i == SelKey) ? (idx == 3'd7) : (idx == 3'd3);
  assign word_lsb = {3'd7 - idx, {$clog2(WORD_W){1'b0}}};
  assign blk      = {asm_q[KeyW-1 -: 3*WORD_W], bus.data_i};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    asm_d    = asm_q;
    k_d      = k_q;
    iv_d     = iv_q;
    c_d      = c_q;
    cvalid_d = cvalid_q;
    kvalid_d = kvalid_q;
    ivalid_d = ivalid_q;
    err_d    = err_q;

    if (enable_i) begin
      kvalid_d = 1'b0;
      ivalid_d = 1'b0;
      err_d    = 1'b0;

      if (consume) begin
        cvalid_d = 1'b0;
      end

      if (state_q == StHold && consume) begin
        c_d      = asm_q[KeyW-1 -: BlkW];
        cvalid_d = 1'b1;
        cnt_d    = 3'd0;
        state_d  = StIdle;
      end

      if (accept) begin
        if (bus.dsel_i == SelRsvd) begin
          err_d = 1'b1;
        end else begin
          if (state_q == StFill && bus.dsel_i != tgt_q) begin
            err_d = 1'b1;
          end
          tgt_d                    = bus.dsel_i;
          asm_d[word_lsb +: WORD_W] = bus.data_i;
          if (last) begin
            cnt_d   = 3'd0;
            state_d = StIdle;
            case (bus.dsel_i)
              SelKey: begin
                k_d      = {asm_q[KeyW-1 -: 7*WORD_W], bus.data_i};
                kvalid_d = 1'b1;
              end
              SelIv: begin
                iv_d     = blk;
                ivalid_d = 1'b1;
              end
              SelCt: begin
                // Output register free (or freed this edge): load directly, else park in HOLD.
                if (!cvalid_q || consume) begin
                  c_d      = blk;
                  cvalid_d = 1'b1;
                end else begin
                  asm_d[KeyW-1 -: BlkW] = blk;
                  state_d               = StHold;
                end
              end
              default: ;
            endcase
          end else begin
            cnt_d   = idx + 3'd1;
            state_d = StFill;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= 3'd0;
      tgt_q    <= SelCt;
      asm_q    <= '0;
      k_q      <= '0;
      iv_q     <= '0;
      c_q      <= '0;
      cvalid_q <= 1'b0;
      kvalid_q <= 1'b0;
      ivalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
      asm_q    <= asm_d;
      k_q      <= k_d;
      iv_q     <= iv_d;
      c_q      <= c_d;
      cvalid_q <= cvalid_d;
      kvalid_q <= kvalid_d;
      ivalid_q <= ivalid_d;
      err_q    <= err_d;
    end
  end

  assign bus.dready_o = dready;
  assign bus.k_o      = k_q;
  assign bus.iv_o     = iv_q;
  assign bus.c_o      = c_q;
  assign bus.cvalid_o = cvalid_q;
  // Pulses are masked while disabled; their flops are frozen like everything else.
  assign bus.kvalid_o = kvalid_q & enable_i;
  assign bus.ivalid_o = ivalid_q & enable_i;
  assign bus.err_o    = err_q & enable_i;
endmodule
